serial_operand_deser: RTL and testbench

SERIAL_OPERAND_DESER -- requirements
Module: serial_operand_deser

---
 rtl/serial_operand_deser.sv | 140 ++++++++++++++
 tb/tb_serial_operand_deser.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_deser.sv
// Serial-to-parallel operand deserializer (LSB first) feeding a one-word holding register.
// Define SERDES_PARITY_CHECK_EN to add a trailing even-parity bit to every frame.
module serial_operand_deser #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_start,
   input  logic                  in_serial,
   output logic [DATA_WIDTH-1:0] out_parallel,
   output logic                  out_valid,
   input  logic                  in_ready,
   output logic                  busy,
   output logic                  overrun,
   output logic                  parity_err
);
   localparam int               CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef SERDES_PARITY_CHECK_EN
   localparam logic [1:0] ST_PARITY = 2'd2;
`endif

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  valid_q, valid_d;
   logic                  ovr_q, ovr_d;
   logic                  word_done;
   logic [DATA_WIDTH-1:0] word_new;
   logic                  accept;
`ifdef SERDES_PARITY_CHECK_EN
   logic                  perr_q, perr_d;
`endif

   assign accept = valid_q & in_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      hold_d    = hold_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      word_done = 1'b0;
      word_new  = shreg_q;
`ifdef SERDES_PARITY_CHECK_EN
      perr_d    = 1'b0;
`endif
      if (accept) begin
         valid_d = 1'b0;
      end

      // A start marker always wins: it opens a frame from IDLE or restarts one in progress.
      if (in_start) begin
         shreg_d    = '0;
         shreg_d[0] = in_serial;
         cnt_d      = CNT_W'(1);
         state_d    = ST_SHIFT;
      end else begin
         case (state_q)
            ST_SHIFT: begin
               shreg_d[cnt_q] = in_serial;
               cnt_d          = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BIT) begin
                  cnt_d = '0;
`ifdef SERDES_PARITY_CHECK_EN
                  state_d = ST_PARITY;
`else
                  state_d   = ST_IDLE;
                  word_done = 1'b1;
                  word_new  = shreg_d;
`endif
               end
            end
`ifdef SERDES_PARITY_CHECK_EN
            ST_PARITY: begin
               state_d = ST_IDLE;
               if (!(^{shreg_q, in_serial})) begin
                  word_done = 1'b1;
               end else begin
                  perr_d = 1'b1;
               end
            end
`endif
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // valid_d already reflects a same-cycle accept, so a full register here means a drop.
      if (word_done) begin
         if (valid_d) begin
            ovr_d = 1'b1;
         end else begin
            hold_d  = word_new;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         hold_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef SERDES_PARITY_CHECK_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
`ifdef SERDES_PARITY_CHECK_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign out_parallel = hold_q;
   assign out_valid    = valid_q;
   assign overrun      = ovr_q;
   assign busy         = (state_q != ST_IDLE);
`ifdef SERDES_PARITY_CHECK_EN
   assign parity_err   = perr_q;
`else
   assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_operand_deser.sv
// Self-checking bench for serial_operand_deser (DATA_WIDTH=8) against a queue-based frame model.
module tb_serial_operand_deser;
   localparam int W = 8;
`ifdef SERDES_PARITY_CHECK_EN
   localparam int PX = 1;
`else
   localparam int PX = 0;
`endif
   localparam int N = W + PX;

   typedef struct packed {
      bit s;
      bit d;
      bit r;
   } stim_t;

   logic         clk = 1'b0;
   logic         resetn;
   logic         in_start;
   logic         in_serial;
   logic         in_ready;
   logic [W-1:0] out_parallel;
   logic         out_valid;
   logic         busy;
   logic         overrun;
   logic         parity_err;

   int checks = 0;
   int errors = 0;

   bit         m_valid, m_busy, m_ovr, m_perr;
   bit [W-1:0] m_data;
   bit         bits[$];
   stim_t      sq[$];

   always #5 clk = ~clk;

   serial_operand_deser #(.DATA_WIDTH(W)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .in_start    (in_start),
      .in_serial   (in_serial),
      .out_parallel(out_parallel),
      .out_valid   (out_valid),
      .in_ready    (in_ready),
      .busy        (busy),
      .overrun     (overrun),
      .parity_err  (parity_err)
   );

   task automatic model_reset();
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
      m_data  = '0;
      bits.delete();
   endtask

   // Drive one cycle of stimulus, then advance the model by the frame rules.
   task automatic step(input bit s, input bit d, input bit r);
      bit [W-1:0] word;
      bit         par;
      bit         acc;
      bit         done;
      @(negedge clk);
      in_start  = s;
      in_serial = d;
      in_ready  = r;
      @(posedge clk);
      if (!resetn) begin
         model_reset();
      end else begin
         acc    = m_valid && r;
         done   = 1'b0;
         m_perr = 1'b0;
         word   = '0;
         if (s) begin
            bits.delete();
            bits.push_back(d);
            m_busy = 1'b1;
         end else if (m_busy) begin
            bits.push_back(d);
         end
         if (m_busy && bits.size() == N) begin
            par = 1'b0;
            foreach (bits[i]) begin
               if (i < W) word[i] = bits[i];
               par ^= bits[i];
            end
            m_busy = 1'b0;
            bits.delete();
            if (PX == 0 || par == 1'b0) done = 1'b1;
            else m_perr = 1'b1;
         end
         if (acc) m_valid = 1'b0;
         if (done) begin
            if (m_valid) m_ovr = 1'b1;
            else begin
               m_data  = word;
               m_valid = 1'b1;
            end
         end
      end
      #1;
   endtask

   function automatic void add_frame(input bit [W-1:0] v, input bit pbit, input bit r);
      for (int i = 0; i < W; i++) sq.push_back('{s: (i == 0), d: v[i], r: r});
      if (PX != 0) sq.push_back('{s: 1'b0, d: pbit, r: r});
   endfunction

   function automatic void add_idle(input int n, input bit r);
      for (int i = 0; i < n; i++) sq.push_back('{s: 1'b0, d: 1'($urandom), r: r});
   endfunction

   task automatic do_reset();
      @(negedge clk);
      resetn   = 1'b0;
      in_start = 1'b0;
      in_ready = 1'b0;
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      in_start  = 1'b1;
      in_serial = 1'b1;
      in_ready  = 1'b0;
      model_reset();
      #2;
      checks++;
      if ({out_valid, busy, overrun, parity_err, out_parallel} !== '0) begin
         errors++;
         $display("FAIL reset_async got v%b b%b o%b p%b d%h exp all zero", out_valid, busy, overrun, parity_err, out_parallel);
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 1'b1);
         checks++;
         if ({out_valid, busy, overrun, parity_err, out_parallel} !== '0) begin
            errors++;
            $display("FAIL reset_held cyc %0d got v%b b%b o%b p%b d%h exp all zero", k, out_valid, busy, overrun, parity_err, out_parallel);
         end
      end
      @(negedge clk);
      in_start = 1'b0;
      resetn   = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      sq.delete();
      add_frame(8'hA5, ^8'hA5, 1'b1);
      add_idle(3, 1'b1);
      foreach (sq[k]) begin
         step(sq[k].s, sq[k].d, sq[k].r);
         checks++;
         if ({out_valid, busy, overrun, parity_err, out_parallel} !== {m_valid, m_busy, m_ovr, m_perr, m_data}) begin
            errors++;
            $display("FAIL single cyc %0d got v%b b%b o%b p%b d%h exp v%b b%b o%b p%b d%h", k + 1, out_valid, busy, overrun, parity_err, out_parallel, m_valid, m_busy, m_ovr, m_perr, m_data);
         end
         if (k == N - 1) begin
            checks++;
            if (out_valid !== 1'b1 || out_parallel !== 8'hA5) begin
               errors++;
               $display("FAIL single_deliver got v%b d%h exp v1 d a5", out_valid, out_parallel);
            end
         end
         if (k == N) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL single_consumed got v%b exp v0", out_valid);
            end
         end
      end
   endtask

   task automatic test_overrun();
      do_reset();
      sq.delete();
      add_frame(8'h3C, ^8'h3C, 1'b0);
      add_frame(8'h81, ^8'h81, 1'b0);
      add_idle(2, 1'b0);
      add_idle(2, 1'b1);
      foreach (sq[k]) begin
         step(sq[k].s, sq[k].d, sq[k].r);
         checks++;
         if ({out_valid, busy, overrun, parity_err, out_parallel} !== {m_valid, m_busy, m_ovr, m_perr, m_data}) begin
            errors++;
            $display("FAIL overrun cyc %0d got v%b b%b o%b p%b d%h exp v%b b%b o%b p%b d%h", k + 1, out_valid, busy, overrun, parity_err, out_parallel, m_valid, m_busy, m_ovr, m_perr, m_data);
         end
         if (k == 2 * N - 1) begin
            checks++;
            if (overrun !== 1'b1 || out_parallel !== 8'h3C) begin
               errors++;
               $display("FAIL overrun_set got o%b d%h exp o1 d 3c", overrun, out_parallel);
            end
         end
         if (k == 2 * N + 1) begin
            checks++;
            if (out_valid !== 1'b1 || out_parallel !== 8'h3C) begin
               errors++;
               $display("FAIL overrun_kept got v%b d%h exp v1 d 3c", out_valid, out_parallel);
            end
         end
         if (k == 2 * N + 2) begin
            checks++;
            if (out_valid !== 1'b0 || overrun !== 1'b1) begin
               errors++;
               $display("FAIL overrun_sticky got v%b o%b exp v0 o1", out_valid, overrun);
            end
         end
      end
   endtask

   task automatic test_accept_same_cycle();
      do_reset();
      sq.delete();
      add_frame(8'h3C, ^8'h3C, 1'b0);
      add_frame(8'h81, ^8'h81, 1'b0);
      add_idle(2, 1'b0);
      sq[2 * N - 1].r = 1'b1;
      foreach (sq[k]) begin
         step(sq[k].s, sq[k].d, sq[k].r);
         checks++;
         if ({out_valid, busy, overrun, parity_err, out_parallel} !== {m_valid, m_busy, m_ovr, m_perr, m_data}) begin
            errors++;
            $display("FAIL same_cycle cyc %0d got v%b b%b o%b p%b d%h exp v%b b%b o%b p%b d%h", k + 1, out_valid, busy, overrun, parity_err, out_parallel, m_valid, m_busy, m_ovr, m_perr, m_data);
         end
         if (k == 2 * N - 1) begin
            checks++;
            if (out_valid !== 1'b1 || overrun !== 1'b0 || out_parallel !== 8'h81) begin
               errors++;
               $display("FAIL same_cycle_load got v%b o%b d%h exp v1 o0 d 81", out_valid, overrun, out_parallel);
            end
         end
      end
   endtask

   task automatic test_abort();
      int nvalid;
      do_reset();
      sq.delete();
      sq.push_back('{s: 1'b1, d: 1'b1, r: 1'b1});
      add_idle(3, 1'b1);
      add_frame(8'h5A, ^8'h5A, 1'b1);
      add_idle(W + 2, 1'b1);
      nvalid = 0;
      foreach (sq[k]) begin
         step(sq[k].s, sq[k].d, sq[k].r);
         if (out_valid === 1'b1) nvalid++;
         checks++;
         if ({out_valid, busy, overrun, parity_err, out_parallel} !== {m_valid, m_busy, m_ovr, m_perr, m_data}) begin
            errors++;
            $display("FAIL abort cyc %0d got v%b b%b o%b p%b d%h exp v%b b%b o%b p%b d%h", k + 1, out_valid, busy, overrun, parity_err, out_parallel, m_valid, m_busy, m_ovr, m_perr, m_data);
         end
         if (k == N + 3) begin
            checks++;
            if (out_valid !== 1'b1 || out_parallel !== 8'h5A) begin
               errors++;
               $display("FAIL abort_deliver got v%b d%h exp v1 d 5a", out_valid, out_parallel);
            end
         end
      end
      checks++;
      if (nvalid != 1) begin
         errors++;
         $display("FAIL abort_count got %0d words exp 1", nvalid);
      end
   endtask

   task automatic test_reset_midframe();
      int nvalid;
      do_reset();
      sq.delete();
      add_frame(8'h11, ^8'h11, 1'b0);
      add_frame(8'h22, ^8'h22, 1'b0);
      sq.push_back('{s: 1'b1, d: 1'b1, r: 1'b0});
      add_idle(2, 1'b0);
      foreach (sq[k]) begin
         step(sq[k].s, sq[k].d, sq[k].r);
         checks++;
         if ({out_valid, busy, overrun, parity_err, out_parallel} !== {m_valid, m_busy, m_ovr, m_perr, m_data}) begin
            errors++;
            $display("FAIL pre_reset cyc %0d got v%b b%b o%b p%b d%h exp v%b b%b o%b p%b d%h", k + 1, out_valid, busy, overrun, parity_err, out_parallel, m_valid, m_busy, m_ovr, m_perr, m_data);
         end
      end
      @(negedge clk);
      #2;
      resetn = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({out_valid, busy, overrun, parity_err, out_parallel} !== '0) begin
         errors++;
         $display("FAIL midframe_reset got v%b b%b o%b p%b d%h exp all zero", out_valid, busy, overrun, parity_err, out_parallel);
      end
      step(1'b0, 1'b1, 1'b1);
      @(negedge clk);
      in_start = 1'b0;
      resetn   = 1'b1;
      sq.delete();
      add_idle(4, 1'b1);
      add_frame(8'hFF, ^8'hFF, 1'b1);
      add_idle(3, 1'b1);
      nvalid = 0;
      foreach (sq[k]) begin
         step(sq[k].s, sq[k].d, sq[k].r);
         if (out_valid === 1'b1) begin
            nvalid++;
            checks++;
            if (out_parallel !== 8'hFF) begin
               errors++;
               $display("FAIL post_reset_word got d%h exp d ff", out_parallel);
            end
         end
         checks++;
         if ({out_valid, busy, overrun, parity_err, out_parallel} !== {m_valid, m_busy, m_ovr, m_perr, m_data}) begin
            errors++;
            $display("FAIL post_reset cyc %0d got v%b b%b o%b p%b d%h exp v%b b%b o%b p%b d%h", k + 1, out_valid, busy, overrun, parity_err, out_parallel, m_valid, m_busy, m_ovr, m_perr, m_data);
         end
      end
      checks++;
      if (nvalid != 1) begin
         errors++;
         $display("FAIL post_reset_count got %0d words exp 1", nvalid);
      end
   endtask

`ifdef SERDES_PARITY_CHECK_EN
   task automatic test_parity();
      do_reset();
      sq.delete();
      add_frame(8'h07, 1'b1, 1'b1);
      add_frame(8'h07, 1'b0, 1'b1);
      add_idle(3, 1'b1);
      foreach (sq[k]) begin
         step(sq[k].s, sq[k].d, sq[k].r);
         checks++;
         if ({out_valid, busy, overrun, parity_err, out_parallel} !== {m_valid, m_busy, m_ovr, m_perr, m_data}) begin
            errors++;
            $display("FAIL parity cyc %0d got v%b b%b o%b p%b d%h exp v%b b%b o%b p%b d%h", k + 1, out_valid, busy, overrun, parity_err, out_parallel, m_valid, m_busy, m_ovr, m_perr, m_data);
         end
         if (k == W) begin
            checks++;
            if (out_valid !== 1'b1 || out_parallel !== 8'h07) begin
               errors++;
               $display("FAIL parity_good got v%b d%h exp v1 d 07", out_valid, out_parallel);
            end
         end
         if (k == 2 * W + 1) begin
            checks++;
            if (parity_err !== 1'b1 || out_valid !== 1'b0 || overrun !== 1'b0) begin
               errors++;
               $display("FAIL parity_bad got pe%b v%b o%b exp pe1 v0 o0", parity_err, out_valid, overrun);
            end
         end
         if (k == 2 * W + 2) begin
            checks++;
            if (parity_err !== 1'b0) begin
               errors++;
               $display("FAIL parity_pulse got pe%b exp pe0", parity_err);
            end
         end
      end
   endtask
`endif

   task automatic test_random();
      bit [W-1:0] v;
      bit         bad;
      do_reset();
      sq.delete();
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 4) == 0) begin
            sq.push_back('{s: 1'b1, d: 1'($urandom), r: 1'b1});
            add_idle($urandom_range(0, N - 2), 1'b1);
         end
         v   = W'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         add_frame(v, (^v) ^ bad, 1'b1);
         add_idle($urandom_range(0, 2), 1'b1);
      end
      add_idle(N + 2, 1'b1);
      foreach (sq[k]) sq[k].r = ($urandom_range(0, 2) != 0);
      foreach (sq[k]) begin
         step(sq[k].s, sq[k].d, sq[k].r);
         checks++;
         if ({out_valid, busy, overrun, parity_err, out_parallel} !== {m_valid, m_busy, m_ovr, m_perr, m_data}) begin
            errors++;
            $display("FAIL random cyc %0d got v%b b%b o%b p%b d%h exp v%b b%b o%b p%b d%h", k + 1, out_valid, busy, overrun, parity_err, out_parallel, m_valid, m_busy, m_ovr, m_perr, m_data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overrun();
      test_accept_same_cycle();
      test_abort();
      test_reset_midframe();
`ifdef SERDES_PARITY_CHECK_EN
      test_parity();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
